bvh_traversal_ctrl: RTL and testbench
=====================================

// Module: bvh_traversal_ctrl
// PURPOSE
//  Per-ray BVH traversal sequencer. Accepts one ray, walks the BVH depth-first (left first, right pushed),
//  issues node fetches, ray-box tests and leaf triangle tests to external units, and returns the closest hit.
//  Sits between ray generation and the shading stage; owns node/box/triangle units for one ray at a time.
// PARAMETERS
//  STACK_DEPTH  32  node-index LIFO entries (index = bvh_node.left/right, 16 b)
//  ROOT_IDX     0   node index where traversal starts
// PORTS
//  clk             in   1    clock
//  rst_n           in   1    asynchronous active-low reset
//  ray_valid/ray_ready in/out 1   ray intake handshake; ray_in in ray (168 b, data_structs::ray)
//  cur_ray         out  168  registered accepted ray, fed to box and triangle units
//  node_req_valid  out  1    node fetch request; node_req_ready in 1; node_req_addr out 16
//  node_rsp_valid  in   1    node data valid (no backpressure); node_rsp_data in 232 bvh_node
//  box_valid       out  1    box test request; box_ready in 1; box_bbox out 168 bbox
//  box_done        in   1    box result pulse; box_hit in 1; box_tnear in 49 signed entry distance
//  tri_valid       out  1    triangle test request; tri_ready in 1; tri_idx out 16
//  tri_done        in   1    in-order triangle result pulse; tri_hit in 1; tri_t in 49 signed
//  res_valid       out  1    result handshake; res_ready in 1
//  res_hit/res_tri_idx/res_t/res_overflow  out 1/16/49/1  closest hit record, stack-overflow flag
// BEHAVIOUR
//  Reset: all valids 0, ray_ready 0, res_* 0, cur_ray 0, stack empty, state IDLE. ray_ready=1 in IDLE only.
//  States: IDLE -> FETCH -> FWAIT -> BOX -> BWAIT -> {LEAF | PUSH | POP} -> ... -> DONE -> IDLE.
//  IDLE: on ray_valid&ray_ready latch ray, best_t=T_MAX (49'h0FFFFFFFFFFFF), hit=0, ovf=0, cur=ROOT_IDX.
//  FETCH: node_req_valid=1, addr=cur, held until node_req_ready; accepted ray -> node_req_valid next cycle.
//  FWAIT: capture node on node_rsp_valid. BOX: box_valid=1 with node.box until box_ready.
//  BWAIT on box_done: miss, or box_tnear >= best_t (signed) -> POP; else size!=0 -> LEAF, size==0 -> PUSH.
//  PUSH: push node.right; cur=node.left -> FETCH. Push while full: push dropped, ovf=1 (sticky per ray).
//  LEAF: issue tri_idx=start..start+size-1 back-to-back, one per tri_valid&tri_ready; responses counted
//   independently, may overlap issue. Response k maps to start+k. Update if tri_hit & tri_t < best_t
//   (strict; ties keep lower index). Leaf complete when rsp count == size and all issued -> POP.
//  Issue/rsp counters 16 b; start+size wrap modulo 2^16 (no check).
//  POP: stack empty -> DONE; else cur=pop -> FETCH. One cycle.
//  DONE: res_valid=1, res_* stable until res_ready; then IDLE (ray_ready next cycle).
//  box_done/tri_done/node_rsp_valid outside their wait states: ignored. Request valids never drop
//   before ready. Async reset in any state aborts ray; no result emitted.
// STRUCTURE
//  data_structs additions: hit_rec {hit, tri_idx[15:0], t[48:0] signed}; const T_MAX = range_default.max;
//   typedef trav_state_e for the FSM encoding.
//  Sub-module bvh_stack: STACK_DEPTH x 16 b LIFO, push/pop/full/empty, async active-low reset.
// TESTING
//  Root box_hit=0 -> one node fetch (addr 0), no tri_valid; res_hit=0, res_t=49'h0FFFFFFFFFFFF.
//  Root leaf start=10 size=3, t=500(hit),200(hit),200(hit) -> res_hit=1, res_tri_idx=11, res_t=200.
//  Root left=1 right=2 both leaves, hit t=300 in 1, t=120 in 2 -> fetch order 0,1,2; res_t=120, idx in node 2.
//  Prune: best_t=100 after node 1, node 2 tnear=150 -> node 2 no tri_valid; result t=100.
//  STACK_DEPTH=2, internal chain depth 4, deepest leaf hits -> res_overflow=1, res_hit=1, result delivered.
//  tri_ready/node_req_ready/res_ready toggled randomly -> requests and res_* held stable; result matches.
//  Reset asserted in LEAF mid-issue -> all valids 0 immediately; after release ray_ready=1, fresh ray correct.

Source files
------------

// File: rtl/bvh_traversal_ctrl_pkg.sv
// Shared types for the BVH traversal controller: ray, box and node payloads,
// the closest-hit record, the no-hit distance and the sequencer state encoding.
package bvh_traversal_ctrl_pkg;

   localparam int unsigned IDX_W   = 16;
   localparam int unsigned T_W     = 49;
   localparam int unsigned COORD_W = 28;

   typedef logic [IDX_W-1:0] node_idx_t;

   typedef struct packed {
      logic [COORD_W-1:0] lo_x, lo_y, lo_z, hi_x, hi_y, hi_z;
   } bbox_t;

   typedef struct packed {
      logic [COORD_W-1:0] org_x, org_y, org_z, dir_x, dir_y, dir_z;
   } ray_t;

   // size == 0 marks an internal node; otherwise a leaf with triangles start..start+size-1
   typedef struct packed {
      bbox_t     box;
      node_idx_t left;
      node_idx_t right;
      node_idx_t start;
      node_idx_t size;
   } bvh_node_t;

   typedef struct packed {
      logic                  hit;
      node_idx_t             tri_idx;
      logic signed [T_W-1:0] t;
   } hit_rec_t;

   // Largest positive distance; the "nothing hit yet" value of best_t
   localparam logic signed [T_W-1:0] T_MAX = 49'h0FFFFFFFFFFFF;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_FWAIT, S_BOX, S_BWAIT, S_LEAF, S_PUSH, S_POP, S_DONE
   } trav_state_e;

endpackage

// File: rtl/bvh_traversal_ctrl_stack.sv
// Node-index LIFO holding deferred right children.
//  push_i/data_i : push when not full (a push while full is dropped)
//  pop_i         : pop when not empty
//  top_o         : current top entry; full_o/empty_o : occupancy flags
module bvh_traversal_ctrl_stack
   import bvh_traversal_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push_i,
   input  logic      pop_i,
   input  node_idx_t data_i,
   output node_idx_t top_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [CNT_W-1:0] cnt_q;
   node_idx_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign wr_ptr  = cnt_q[PTR_W-1:0];
   assign rd_ptr  = PTR_W'(cnt_q - CNT_W'(1));
   assign top_o   = mem_q[rd_ptr];

   // Occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (push_i && !full_o) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop_i && !empty_o) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Storage; contents are meaningless while the count says empty
   always_ff @(posedge clk) begin
      if (push_i && !full_o) begin
         mem_q[wr_ptr] <= data_i;
      end
   end

endmodule

// File: rtl/bvh_traversal_ctrl.sv
// Per-ray BVH traversal sequencer. Walks the tree depth-first (left child
// first, right child deferred on a LIFO), drives node fetch, ray-box and
// ray-triangle units, and returns the closest hit for the accepted ray.
//  ray_valid/ray_ready/ray_in   : ray intake; cur_ray is the latched ray
//  node_req_* / node_rsp_*      : node fetch request and response
//  box_*                        : box test request, result pulse with entry distance
//  tri_*                        : triangle test request, in-order result pulses
//  res_*                        : closest hit record and overflow flag handshake
module bvh_traversal_ctrl
   import bvh_traversal_ctrl_pkg::*;
#(
   parameter int unsigned STACK_DEPTH = 32,
   parameter int unsigned ROOT_IDX    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ray_valid,
   output logic                  ray_ready,
   input  ray_t                  ray_in,
   output ray_t                  cur_ray,
   output logic                  node_req_valid,
   input  logic                  node_req_ready,
   output logic [IDX_W-1:0]      node_req_addr,
   input  logic                  node_rsp_valid,
   input  bvh_node_t             node_rsp_data,
   output logic                  box_valid,
   input  logic                  box_ready,
   output bbox_t                 box_bbox,
   input  logic                  box_done,
   input  logic                  box_hit,
   input  logic signed [T_W-1:0] box_tnear,
   output logic                  tri_valid,
   input  logic                  tri_ready,
   output logic [IDX_W-1:0]      tri_idx,
   input  logic                  tri_done,
   input  logic                  tri_hit,
   input  logic signed [T_W-1:0] tri_t,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  res_hit,
   output logic [IDX_W-1:0]      res_tri_idx,
   output logic signed [T_W-1:0] res_t,
   output logic                  res_overflow
);

   trav_state_e state_q, state_d;
   logic        ray_ready_q, ray_ready_d;
   ray_t        cur_ray_q, cur_ray_d;
   logic        node_req_valid_q, node_req_valid_d;
   node_idx_t   cur_q, cur_d;
   bvh_node_t   node_q, node_d;
   logic        box_valid_q, box_valid_d;
   logic        tri_valid_q, tri_valid_d;
   node_idx_t   tri_idx_q, tri_idx_d;
   node_idx_t   iss_q, iss_d;
   node_idx_t   rsp_q, rsp_d;
   hit_rec_t    best_q, best_d;
   logic        ovf_q, ovf_d;
   logic        res_valid_q, res_valid_d;
   hit_rec_t    res_q, res_d;
   logic        res_ovf_q, res_ovf_d;

   logic        push_c, pop_c;
   node_idx_t   stk_top;
   logic        stk_full, stk_empty;

   bvh_traversal_ctrl_stack #(.DEPTH(STACK_DEPTH)) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .data_i  (node_q.right),
      .top_o   (stk_top),
      .full_o  (stk_full),
      .empty_o (stk_empty)
   );

   // Next-state and output decisions
   always_comb begin
      state_d          = state_q;
      cur_ray_d        = cur_ray_q;
      node_req_valid_d = node_req_valid_q;
      cur_d            = cur_q;
      node_d           = node_q;
      box_valid_d      = box_valid_q;
      tri_valid_d      = tri_valid_q;
      tri_idx_d        = tri_idx_q;
      iss_d            = iss_q;
      rsp_d            = rsp_q;
      best_d           = best_q;
      ovf_d            = ovf_q;
      res_valid_d      = res_valid_q;
      res_d            = res_q;
      res_ovf_d        = res_ovf_q;
      push_c           = 1'b0;
      pop_c            = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (ray_valid && ray_ready_q) begin
               cur_ray_d        = ray_in;
               best_d           = '{hit: 1'b0, tri_idx: '0, t: T_MAX};
               ovf_d            = 1'b0;
               cur_d            = IDX_W'(ROOT_IDX);
               node_req_valid_d = 1'b1;
               state_d          = S_FETCH;
            end
         end
         S_FETCH: begin
            if (node_req_ready) begin
               node_req_valid_d = 1'b0;
               state_d          = S_FWAIT;
            end
         end
         S_FWAIT: begin
            if (node_rsp_valid) begin
               node_d      = node_rsp_data;
               box_valid_d = 1'b1;
               state_d     = S_BOX;
            end
         end
         S_BOX: begin
            if (box_ready) begin
               box_valid_d = 1'b0;
               state_d     = S_BWAIT;
            end
         end
         S_BWAIT: begin
            // Boxes entered no nearer than the current best cannot improve it
            if (box_done) begin
               if (!box_hit || ($signed(box_tnear) >= $signed(best_q.t))) begin
                  state_d = S_POP;
               end else if (node_q.size != '0) begin
                  iss_d       = '0;
                  rsp_d       = '0;
                  tri_idx_d   = node_q.start;
                  tri_valid_d = 1'b1;
                  state_d     = S_LEAF;
               end else begin
                  state_d = S_PUSH;
               end
            end
         end
         S_PUSH: begin
            push_c           = 1'b1;
            ovf_d            = ovf_q | stk_full;
            cur_d            = node_q.left;
            node_req_valid_d = 1'b1;
            state_d          = S_FETCH;
         end
         S_LEAF: begin
            if ((iss_q == node_q.size) && (rsp_q == node_q.size)) begin
               state_d = S_POP;
            end else begin
               if (tri_valid_q && tri_ready) begin
                  iss_d = iss_q + IDX_W'(1);
                  if (iss_d == node_q.size) begin
                     tri_valid_d = 1'b0;
                  end else begin
                     tri_idx_d = tri_idx_q + IDX_W'(1);
                  end
               end
               // Responses return in issue order, so response k is triangle start+k
               if (tri_done && (rsp_q != node_q.size)) begin
                  rsp_d = rsp_q + IDX_W'(1);
                  if (tri_hit && ($signed(tri_t) < $signed(best_q.t))) begin
                     best_d = '{hit: 1'b1, tri_idx: node_q.start + rsp_q, t: tri_t};
                  end
               end
            end
         end
         S_POP: begin
            if (stk_empty) begin
               res_d       = best_q;
               res_ovf_d   = ovf_q;
               res_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               pop_c            = 1'b1;
               cur_d            = stk_top;
               node_req_valid_d = 1'b1;
               state_d          = S_FETCH;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ray_ready_d = (state_d == S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         ray_ready_q      <= 1'b0;
         cur_ray_q        <= '0;
         node_req_valid_q <= 1'b0;
         cur_q            <= '0;
         node_q           <= '0;
         box_valid_q      <= 1'b0;
         tri_valid_q      <= 1'b0;
         tri_idx_q        <= '0;
         iss_q            <= '0;
         rsp_q            <= '0;
         best_q           <= '0;
         ovf_q            <= 1'b0;
         res_valid_q      <= 1'b0;
         res_q            <= '0;
         res_ovf_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         ray_ready_q      <= ray_ready_d;
         cur_ray_q        <= cur_ray_d;
         node_req_valid_q <= node_req_valid_d;
         cur_q            <= cur_d;
         node_q           <= node_d;
         box_valid_q      <= box_valid_d;
         tri_valid_q      <= tri_valid_d;
         tri_idx_q        <= tri_idx_d;
         iss_q            <= iss_d;
         rsp_q            <= rsp_d;
         best_q           <= best_d;
         ovf_q            <= ovf_d;
         res_valid_q      <= res_valid_d;
         res_q            <= res_d;
         res_ovf_q        <= res_ovf_d;
      end
   end

   assign ray_ready      = ray_ready_q;
   assign cur_ray        = cur_ray_q;
   assign node_req_valid = node_req_valid_q;
   assign node_req_addr  = cur_q;
   assign box_valid      = box_valid_q;
   assign box_bbox       = node_q.box;
   assign tri_valid      = tri_valid_q;
   assign tri_idx        = tri_idx_q;
   assign res_valid      = res_valid_q;
   assign res_hit        = res_q.hit;
   assign res_tri_idx    = res_q.tri_idx;
   assign res_t          = res_q.t;
   assign res_overflow   = res_ovf_q;

endmodule

// File: tb/tb_bvh_traversal_ctrl.sv
// Directed bench for bvh_traversal_ctrl: a table-driven node/box/triangle
// responder surrounds the DUT; each scenario checks fetch order, triangle
// issue count and the returned hit record against hand-computed values.
module tb_bvh_traversal_ctrl;
   import bvh_traversal_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                  ray_valid = 1'b0;
   logic                  ray_ready;
   ray_t                  ray_in = '0;
   ray_t                  cur_ray;
   logic                  node_req_valid;
   logic                  node_req_ready = 1'b0;
   logic [IDX_W-1:0]      node_req_addr;
   logic                  node_rsp_valid = 1'b0;
   bvh_node_t             node_rsp_data = '0;
   logic                  box_valid;
   logic                  box_ready = 1'b0;
   bbox_t                 box_bbox;
   logic                  box_done = 1'b0;
   logic                  box_hit = 1'b0;
   logic signed [T_W-1:0] box_tnear = '0;
   logic                  tri_valid;
   logic                  tri_ready = 1'b0;
   logic [IDX_W-1:0]      tri_idx;
   logic                  tri_done = 1'b0;
   logic                  tri_hit = 1'b0;
   logic signed [T_W-1:0] tri_t = '0;
   logic                  res_valid;
   logic                  res_ready = 1'b0;
   logic                  res_hit;
   logic [IDX_W-1:0]      res_tri_idx;
   logic signed [T_W-1:0] res_t;
   logic                  res_overflow;

   bvh_traversal_ctrl #(.STACK_DEPTH(2), .ROOT_IDX(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_in(ray_in), .cur_ray(cur_ray),
      .node_req_valid(node_req_valid), .node_req_ready(node_req_ready),
      .node_req_addr(node_req_addr),
      .node_rsp_valid(node_rsp_valid), .node_rsp_data(node_rsp_data),
      .box_valid(box_valid), .box_ready(box_ready), .box_bbox(box_bbox),
      .box_done(box_done), .box_hit(box_hit), .box_tnear(box_tnear),
      .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_idx(tri_idx),
      .tri_done(tri_done), .tri_hit(tri_hit), .tri_t(tri_t),
      .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
      .res_tri_idx(res_tri_idx), .res_t(res_t), .res_overflow(res_overflow)
   );

   // Scene tables written by the stimulus, read by the responder
   bvh_node_t             node_mem [64];
   logic                  bx_hit   [64];
   logic signed [T_W-1:0] bx_tnear [64];
   logic                  tr_hit   [256];
   logic signed [T_W-1:0] tr_t     [256];
   bit                    rnd_mode = 1'b0;

   // Responder state and observations
   logic [IDX_W-1:0] m_fetch_q [$];
   logic [IDX_W-1:0] m_tri_q [$];
   int               fetch_log [$];
   logic [IDX_W-1:0] last_addr = '0;
   bit               box_due = 1'b0;
   int               tri_iss_cnt = 0;
   int               res_cnt = 0;
   int               acc_cnt = 0;
   int               hold_err = 0;
   logic             o_hit = 1'b0;
   logic [IDX_W-1:0] o_idx = '0;
   logic [T_W-1:0]   o_t = '0;
   logic             o_ovf = 1'b0;
   bit               p_nr = 0, p_bx = 0, p_tr = 0, p_rs = 0;
   logic [IDX_W-1:0] p_addr = '0, p_tidx = '0;
   bbox_t            p_bbox = '0;
   logic [66:0]      p_res = '0;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [167:0] act, input logic [167:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Responder: sample handshakes at the edge, drive replies 1 time unit later
   always begin
      logic [IDX_W-1:0] a;
      @(posedge clk);
      if (!rst_n) begin
         m_fetch_q.delete();
         m_tri_q.delete();
         box_due = 1'b0;
         p_nr = 0; p_bx = 0; p_tr = 0; p_rs = 0;
      end else begin
         if (p_nr && !(node_req_valid && node_req_addr == p_addr)) hold_err++;
         if (p_bx && !(box_valid && box_bbox == p_bbox)) hold_err++;
         if (p_tr && !(tri_valid && tri_idx == p_tidx)) hold_err++;
         if (p_rs && !(res_valid && {res_hit, res_tri_idx, res_t, res_overflow} == p_res))
            hold_err++;
         p_nr = node_req_valid && !node_req_ready; p_addr = node_req_addr;
         p_bx = box_valid && !box_ready;           p_bbox = box_bbox;
         p_tr = tri_valid && !tri_ready;           p_tidx = tri_idx;
         p_rs = res_valid && !res_ready;
         p_res = {res_hit, res_tri_idx, res_t, res_overflow};
         if (node_req_valid && node_req_ready) begin
            m_fetch_q.push_back(node_req_addr);
            fetch_log.push_back(int'(node_req_addr));
            last_addr = node_req_addr;
         end
         if (box_valid && box_ready) box_due = 1'b1;
         if (tri_valid && tri_ready) begin
            m_tri_q.push_back(tri_idx);
            tri_iss_cnt++;
         end
         if (res_valid && res_ready) begin
            o_hit = res_hit; o_idx = res_tri_idx; o_t = res_t; o_ovf = res_overflow;
            res_cnt++;
         end
         if (ray_valid && ray_ready) acc_cnt++;
      end
      #1;
      node_rsp_valid = 1'b0;
      box_done       = 1'b0;
      tri_done       = 1'b0;
      if (rst_n) begin
         if (m_fetch_q.size() > 0) begin
            a = m_fetch_q.pop_front();
            node_rsp_valid = 1'b1;
            node_rsp_data  = node_mem[a[5:0]];
         end
         if (box_due) begin
            box_done  = 1'b1;
            box_hit   = bx_hit[last_addr[5:0]];
            box_tnear = bx_tnear[last_addr[5:0]];
            box_due   = 1'b0;
         end
         if (m_tri_q.size() > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
            a = m_tri_q.pop_front();
            tri_done = 1'b1;
            tri_hit  = tr_hit[a[7:0]];
            tri_t    = tr_t[a[7:0]];
         end
      end
      node_req_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      box_ready      = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      tri_ready      = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      res_ready      = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   task automatic clear_scene();
      for (int i = 0; i < 64; i++) begin
         node_mem[i] = '0;
         bx_hit[i]   = 1'b1;
         bx_tnear[i] = '0;
      end
      for (int i = 0; i < 256; i++) begin
         tr_hit[i] = 1'b0;
         tr_t[i]   = '0;
      end
   endtask

   task automatic set_node(input int i, input int l, input int r, input int s, input int n);
      node_mem[i].box.lo_x = COORD_W'(i + 7);
      node_mem[i].box.hi_z = COORD_W'(i * 3 + 1);
      node_mem[i].left     = IDX_W'(l);
      node_mem[i].right    = IDX_W'(r);
      node_mem[i].start    = IDX_W'(s);
      node_mem[i].size     = IDX_W'(n);
   endtask

   task automatic set_tri(input int i, input logic h, input int t);
      tr_hit[i] = h;
      tr_t[i]   = T_W'(t);
   endtask

   function automatic ray_t mk_ray(input int k);
      ray_t r;
      r.org_x = COORD_W'(k);      r.org_y = COORD_W'(k + 11); r.org_z = COORD_W'(k + 22);
      r.dir_x = COORD_W'(k * 5);  r.dir_y = 28'hFFFF000;      r.dir_z = COORD_W'(k + 99);
      return r;
   endfunction

   task automatic send_ray(input string tag, input int k);
      int a0;
      a0 = acc_cnt;
      @(negedge clk);
      ray_valid = 1'b1;
      ray_in    = mk_ray(k);
      for (int i = 0; i < 50 && acc_cnt == a0; i++) @(negedge clk);
      ray_valid = 1'b0;
      check({tag, "_accept"}, 168'(acc_cnt - a0), 168'(1));
      check({tag, "_cur_ray"}, cur_ray, mk_ray(k));
   endtask

   task automatic run_ray(input string tag, input int k);
      int r0;
      r0 = res_cnt;
      send_ray(tag, k);
      for (int i = 0; i < 3000 && res_cnt == r0; i++) @(negedge clk);
      check({tag, "_result"}, 168'(res_cnt - r0), 168'(1));
   endtask

   task automatic check_res(input string tag, input logic h, input int idx,
                            input logic [T_W-1:0] t, input logic ovf);
      check({tag, "_hit"}, 168'(o_hit), 168'(h));
      check({tag, "_idx"}, 168'(o_idx), 168'(idx));
      check({tag, "_t"}, 168'(o_t), 168'(t));
      check({tag, "_ovf"}, 168'(o_ovf), 168'(ovf));
   endtask

   initial begin
      int f0, t0, r0;
      #2_000_000;
      $display("FAIL watchdog");
      $fatal(1, "timeout");
   end

   initial begin
      int f0, t0, r0;
      clear_scene();
      repeat (3) @(negedge clk);
      check("rst_ray_ready", 168'(ray_ready), 168'(0));
      check("rst_valids", 168'({node_req_valid, box_valid, tri_valid, res_valid}), 168'(0));
      check("rst_res", 168'({res_hit, res_tri_idx, res_t, res_overflow}), 168'(0));
      check("rst_cur_ray", cur_ray, 168'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_ray_ready", 168'(ray_ready), 168'(1));

      // Root box miss: one fetch, no triangles, empty record
      clear_scene();
      bx_hit[0] = 1'b0;
      f0 = fetch_log.size(); t0 = tri_iss_cnt;
      run_ray("t1", 1);
      check("t1_nfetch", 168'(fetch_log.size() - f0), 168'(1));
      check("t1_fetch0", 168'(fetch_log[f0]), 168'(0));
      check("t1_ntri", 168'(tri_iss_cnt - t0), 168'(0));
      check_res("t1", 1'b0, 0, T_MAX, 1'b0);

      // Root leaf, equal t on two triangles keeps the lower index
      clear_scene();
      set_node(0, 0, 0, 10, 3);
      set_tri(10, 1'b1, 500); set_tri(11, 1'b1, 200); set_tri(12, 1'b1, 200);
      t0 = tri_iss_cnt;
      run_ray("t2", 2);
      check("t2_ntri", 168'(tri_iss_cnt - t0), 168'(3));
      check_res("t2", 1'b1, 11, 49'd200, 1'b0);

      // Two leaves under the root, nearer hit in the right leaf
      clear_scene();
      set_node(0, 1, 2, 0, 0);
      set_node(1, 0, 0, 20, 1);
      set_node(2, 0, 0, 30, 2);
      set_tri(20, 1'b1, 300); set_tri(30, 1'b0, 50); set_tri(31, 1'b1, 120);
      f0 = fetch_log.size();
      run_ray("t3", 3);
      check("t3_nfetch", 168'(fetch_log.size() - f0), 168'(3));
      check("t3_fetch0", 168'(fetch_log[f0]), 168'(0));
      check("t3_fetch1", 168'(fetch_log[f0 + 1]), 168'(1));
      check("t3_fetch2", 168'(fetch_log[f0 + 2]), 168'(2));
      check_res("t3", 1'b1, 31, 49'd120, 1'b0);

      // Right box entered exactly at best_t is pruned
      clear_scene();
      set_node(0, 1, 2, 0, 0);
      set_node(1, 0, 0, 20, 1);
      set_node(2, 0, 0, 30, 1);
      set_tri(20, 1'b1, 100); set_tri(30, 1'b1, 10);
      bx_tnear[2] = 49'd100;
      f0 = fetch_log.size(); t0 = tri_iss_cnt;
      run_ray("t4", 4);
      check("t4_nfetch", 168'(fetch_log.size() - f0), 168'(3));
      check("t4_ntri", 168'(tri_iss_cnt - t0), 168'(1));
      check_res("t4", 1'b1, 20, 49'd100, 1'b0);

      // Chain deeper than the 2-entry stack: third push dropped, overflow flagged
      clear_scene();
      set_node(0, 1, 10, 0, 0);
      set_node(1, 2, 11, 0, 0);
      set_node(2, 3, 12, 0, 0);
      set_node(3, 0, 0, 40, 1);
      set_tri(40, 1'b1, 50);
      bx_hit[10] = 1'b0; bx_hit[11] = 1'b0; bx_hit[12] = 1'b0;
      f0 = fetch_log.size();
      run_ray("t5", 5);
      check("t5_nfetch", 168'(fetch_log.size() - f0), 168'(6));
      check("t5_fetch4", 168'(fetch_log[f0 + 4]), 168'(11));
      check("t5_fetch5", 168'(fetch_log[f0 + 5]), 168'(10));
      check_res("t5", 1'b1, 40, 49'd50, 1'b1);

      // Random backpressure on every ready and on triangle returns
      clear_scene();
      set_node(0, 1, 2, 0, 0);
      set_node(1, 0, 0, 20, 1);
      set_node(2, 0, 0, 30, 2);
      set_tri(20, 1'b1, 300); set_tri(30, 1'b0, 50); set_tri(31, 1'b1, 120);
      rnd_mode = 1'b1;
      for (int k = 0; k < 3; k++) begin
         run_ray("t6", 6 + k);
         check_res("t6", 1'b1, 31, 49'd120, 1'b0);
      end
      rnd_mode = 1'b0;
      @(negedge clk);
      check("t6_hold", 168'(hold_err), 168'(0));

      // Reset in the middle of triangle issue aborts the ray
      clear_scene();
      set_node(0, 0, 0, 50, 8);
      t0 = tri_iss_cnt; r0 = res_cnt;
      send_ray("t7", 9);
      for (int i = 0; i < 200 && (tri_iss_cnt - t0) < 2; i++) @(negedge clk);
      check("t7_mid_issue", 168'(tri_valid), 168'(1));
      #2 rst_n = 1'b0;
      #1;
      check("t7_rst_valids", 168'({node_req_valid, box_valid, tri_valid, res_valid}), 168'(0));
      check("t7_rst_ray_ready", 168'(ray_ready), 168'(0));
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t7_ray_ready", 168'(ray_ready), 168'(1));
      check("t7_no_result", 168'(res_cnt - r0), 168'(0));
      clear_scene();
      set_node(0, 0, 0, 10, 3);
      set_tri(10, 1'b1, 500); set_tri(11, 1'b1, 200); set_tri(12, 1'b1, 200);
      run_ray("t7b", 10);
      check_res("t7b", 1'b1, 11, 49'd200, 1'b0);
      check("end_hold", 168'(hold_err), 168'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
